// File: rtl/trap_control.sv
// Machine-mode trap sequencer: owns the M-mode trap CSRs, flushes trapping/mret instructions
// and holds a PC redirect to fetch until accepted. Optional vectored mtvec via TRAP_VECTORED_EN.
module trap_control #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic        ins_illegal,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        trap_return,
  input  logic        irq_ext,
  input  logic        csr_wen,
  input  logic [11:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        mstatus_mie, mstatus_mpie, mie_meie;
  logic [31:0] mtvec, mepc, mcause, mtval, target;

  logic        irq_pending, trap_take, mret_take;
  logic [31:0] trap_cause, trap_tval, mtvec_base, trap_target, next_target;

  // Redirect handshake: redirect_valid rises the cycle after the event and redirect_pc
  // stays constant until the cycle where redirect_valid & redirect_ready are both high.
  always_comb begin
    irq_pending = irq_ext & mstatus_mie & mie_meie;
    trap_take   = 1'b0;
    mret_take   = 1'b0;
    trap_cause  = '0;
    trap_tval   = '0;
    state_next  = state;
    if (state == IDLE && valid) begin
      if (irq_pending) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_IRQ;
      end else if (ins_illegal) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_ILLEGAL;
        trap_tval  = ins;
      end else if (ebreak) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_EBREAK;
        trap_tval  = pc;
      end else if (ecall) begin
        trap_take  = 1'b1;
        trap_cause = CAUSE_ECALL;
      end
      mret_take = trap_return & ~trap_take;
    end
    if (trap_take || mret_take) state_next = REDIRECT;
    if (state == REDIRECT && redirect_ready) state_next = IDLE;
    flush = trap_take | mret_take;
  end

  always_comb begin
    mtvec_base  = mtvec & 32'hFFFF_FFFC;
    trap_target = mtvec_base;
`ifdef TRAP_VECTORED_EN
    // Interrupts have top priority, so a taken irq is the only cause with bit 31 set.
    if (mtvec[1:0] == 2'b01 && trap_cause[31])
      trap_target = mtvec_base + {trap_cause[29:0], 2'b00};
`endif
    next_target = trap_take ? trap_target : mepc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RESET & 32'hFFFF_FFFC;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
      target       <= '0;
    end else begin
      state <= state_next;
      if (flush) target <= next_target;
      if (trap_take) begin
        mepc         <= pc & 32'hFFFF_FFFC;
        mcause       <= trap_cause;
        mtval        <= trap_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_take) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_wen && state == IDLE) begin
        case (csr_waddr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
          end
          ADDR_MIE:    mie_meie <= csr_wdata[11];
`ifdef TRAP_VECTORED_EN
          ADDR_MTVEC:  mtvec    <= csr_wdata;
`else
          ADDR_MTVEC:  mtvec    <= csr_wdata & 32'hFFFF_FFFC;
`endif
          ADDR_MEPC:   mepc     <= csr_wdata & 32'hFFFF_FFFC;
          ADDR_MCAUSE: mcause   <= csr_wdata;
          ADDR_MTVAL:  mtval    <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  assign stall          = (state == REDIRECT);
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = target;

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b1;
    case (csr_raddr)
      ADDR_MSTATUS: begin
        csr_rdata[12:11] = 2'b11;
        csr_rdata[7]     = mstatus_mpie;
        csr_rdata[3]     = mstatus_mie;
      end
      ADDR_MIE:    csr_rdata[11] = mie_meie;
      ADDR_MTVEC:  csr_rdata     = mtvec;
      ADDR_MEPC:   csr_rdata     = mepc;
      ADDR_MCAUSE: csr_rdata     = mcause;
      ADDR_MTVAL:  csr_rdata     = mtval;
      ADDR_MIP:    csr_rdata[11] = irq_ext;
      default:     csr_hit       = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_control.sv
// Directed bench for trap_control; define TRAP_VECTORED_EN to also cover vectored targets.
module tb_trap_control;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] EXP_MTVEC_201 = 32'h0000_0201;
  localparam logic [31:0] EXP_IRQ_TGT   = 32'h0000_022C;
`else
  localparam logic [31:0] EXP_MTVEC_201 = 32'h0000_0200;
  localparam logic [31:0] EXP_IRQ_TGT   = 32'h0000_0200;
`endif

  logic        clk, rst_n, valid, ins_illegal, ecall, ebreak, trap_return, irq_ext;
  logic [31:0] pc, ins, csr_wdata, csr_rdata, redirect_pc;
  logic        csr_wen, csr_hit, flush, stall, redirect_valid, redirect_ready;
  logic [11:0] csr_waddr, csr_raddr;

  int checks = 0;
  int errors = 0;

  trap_control #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pc(pc), .ins(ins),
    .ins_illegal(ins_illegal), .ecall(ecall), .ebreak(ebreak), .trap_return(trap_return),
    .irq_ext(irq_ext), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_hit(csr_hit), .flush(flush),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid = 0; ins_illegal = 0; ecall = 0; ebreak = 0; trap_return = 0;
    csr_wen = 0; csr_waddr = '0; csr_wdata = '0; pc = '0; ins = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wen = 1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_wen = 0;
  endtask

  task automatic accept();
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0h exp 0", flush); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0h exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got %h exp 0", redirect_pc); end
    csr_raddr = 12'h305; #1;
    checks++; if (csr_rdata !== 32'h1000) begin errors++; $display("FAIL reset_mtvec got %h exp 00001000", csr_rdata); end
    csr_raddr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp 00001800", csr_rdata); end
    csr_raddr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mcause got %h exp 0", csr_rdata); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_illegal();
    csr_write(12'h305, 32'h100);
    valid = 1; ins_illegal = 1; pc = 32'h40; ins = 32'hFFFF_FFFF; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL ill_flush got %0h exp 1", flush); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL ill_rv_early got %0h exp 0", redirect_valid); end
    tick(); clear_inputs(); #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL ill_rv got %0h exp 1", redirect_valid); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ill_stall got %0h exp 1", stall); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL ill_rpc got %h exp 00000100", redirect_pc); end
    csr_raddr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL ill_mepc got %h exp 00000040", csr_rdata); end
    csr_raddr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'd2) begin errors++; $display("FAIL ill_mcause got %h exp 2", csr_rdata); end
    csr_raddr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ill_mtval got %h exp ffffffff", csr_rdata); end
    valid = 1; ins_illegal = 1; pc = 32'h44; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ill_flush_in_redirect got %0h exp 0", flush); end
    accept(); clear_inputs(); #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL ill_rv_after got %0h exp 0", redirect_valid); end
    csr_raddr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL ill_mepc_kept got %h exp 00000040", csr_rdata); end
  endtask

  task automatic test_ecall_mret();
    csr_write(12'h300, 32'h8);
    csr_raddr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1808) begin errors++; $display("FAIL ec_mstatus_pre got %h exp 00001808", csr_rdata); end
    valid = 1; ecall = 1; pc = 32'h80;
    tick(); clear_inputs();
    csr_raddr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'd11) begin errors++; $display("FAIL ec_mcause got %h exp 0000000b", csr_rdata); end
    csr_raddr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL ec_mstatus got %h exp 00001880", csr_rdata); end
    csr_raddr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL ec_mtval got %h exp 0", csr_rdata); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL ec_rpc got %h exp 00000100", redirect_pc); end
    accept();
    valid = 1; trap_return = 1; pc = 32'h200; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL mret_flush got %0h exp 1", flush); end
    tick(); clear_inputs(); #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL mret_rv got %0h exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL mret_rpc got %h exp 00000080", redirect_pc); end
    csr_raddr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp 00001888", csr_rdata); end
    accept();
    valid = 1; ecall = 1; trap_return = 1; pc = 32'h90;
    tick(); clear_inputs();
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL both_rpc got %h exp 00000100", redirect_pc); end
    csr_raddr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h90) begin errors++; $display("FAIL both_mepc got %h exp 00000090", csr_rdata); end
    csr_raddr = 12'h300; #1;
    checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL both_mstatus got %h exp 00001880", csr_rdata); end
    accept();
  endtask

  task automatic test_backpressure_reset();
    valid = 1; ecall = 1; pc = 32'h84;
    tick(); clear_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL bp_rv[%0d] got %0h exp 1", i, redirect_valid); end
      checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL bp_rpc[%0d] got %h exp 00000100", i, redirect_pc); end
      tick();
    end
    rst_n = 0;
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %0h exp 0", redirect_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", stall); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_rpc got %h exp 0", redirect_pc); end
    csr_raddr = 12'h305; #1;
    checks++; if (csr_rdata !== 32'h1000) begin errors++; $display("FAIL rst_mtvec got %h exp 00001000", csr_rdata); end
    csr_raddr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h exp 0", csr_rdata); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_irq_priority();
    csr_write(12'h305, 32'h100);
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'hFFFF_FFFF);
    csr_raddr = 12'h304; #1;
    checks++; if (csr_rdata !== 32'h800) begin errors++; $display("FAIL irq_mie got %h exp 00000800", csr_rdata); end
    irq_ext = 1; valid = 1; ebreak = 1; pc = 32'h20;
    csr_wen = 1; csr_waddr = 12'h343; csr_wdata = 32'hDEAD; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL irq_flush got %0h exp 1", flush); end
    tick(); clear_inputs(); irq_ext = 0;
    csr_raddr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got %h exp 8000000b", csr_rdata); end
    csr_raddr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h20) begin errors++; $display("FAIL irq_mepc got %h exp 00000020", csr_rdata); end
    csr_raddr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL irq_mtval_drop got %h exp 0", csr_rdata); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL irq_rpc got %h exp 00000100", redirect_pc); end
    accept();
  endtask

  task automatic test_masking();
    irq_ext = 1; csr_raddr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h800) begin errors++; $display("FAIL mask_mip got %h exp 00000800", csr_rdata); end
    valid = 1; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mask_flush got %0h exp 0", flush); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mask_stall got %0h exp 0", stall); end
    ebreak = 1; pc = 32'h24;
    tick(); clear_inputs();
    csr_raddr = 12'h342; #1;
    checks++; if (csr_rdata !== 32'd3) begin errors++; $display("FAIL mask_ebreak_mcause got %h exp 3", csr_rdata); end
    csr_raddr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'h24) begin errors++; $display("FAIL mask_ebreak_mtval got %h exp 00000024", csr_rdata); end
    accept();
    csr_write(12'h300, 32'h8);
    #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL novalid_flush got %0h exp 0", flush); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL novalid_stall got %0h exp 0", stall); end
    irq_ext = 0; csr_raddr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mip_clear got %h exp 0", csr_rdata); end
  endtask

  task automatic test_csr_access();
    csr_write(12'h341, 32'h123);
    csr_write(12'h343, 32'h55);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_raddr = 12'h341; #1;
    checks++; if (csr_rdata !== 32'h120) begin errors++; $display("FAIL csr_mepc got %h exp 00000120", csr_rdata); end
    csr_raddr = 12'h343; #1;
    checks++; if (csr_rdata !== 32'h55) begin errors++; $display("FAIL csr_mtval got %h exp 00000055", csr_rdata); end
    csr_raddr = 12'h344; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL csr_mip_ro got %h exp 0", csr_rdata); end
    checks++; if (csr_hit !== 1'b1) begin errors++; $display("FAIL csr_hit_mip got %0h exp 1", csr_hit); end
    csr_raddr = 12'h7C0; #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL csr_unowned got %h exp 0", csr_rdata); end
    checks++; if (csr_hit !== 1'b0) begin errors++; $display("FAIL csr_hit_unowned got %0h exp 0", csr_hit); end
  endtask

  task automatic test_mtvec_mode();
    csr_write(12'h305, 32'h201);
    csr_write(12'h300, 32'h8);
    csr_raddr = 12'h305; #1;
    checks++; if (csr_rdata !== EXP_MTVEC_201) begin errors++; $display("FAIL vec_mtvec got %h exp %h", csr_rdata, EXP_MTVEC_201); end
    irq_ext = 1; valid = 1; pc = 32'h60;
    tick(); clear_inputs(); irq_ext = 0; #1;
    checks++; if (redirect_pc !== EXP_IRQ_TGT) begin errors++; $display("FAIL vec_irq_rpc got %h exp %h", redirect_pc, EXP_IRQ_TGT); end
    accept();
    valid = 1; ins_illegal = 1; pc = 32'h64; ins = 32'h0;
    tick(); clear_inputs(); #1;
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL vec_exc_rpc got %h exp 00000200", redirect_pc); end
    accept();
  endtask

  initial begin
    rst_n = 0; irq_ext = 0; redirect_ready = 0; csr_raddr = '0;
    clear_inputs();
    test_reset();
    test_illegal();
    test_ecall_mret();
    test_backpressure_reset();
    test_irq_priority();
    test_masking();
    test_csr_access();
    test_mtvec_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_control.md
# trap_control

Machine-mode trap sequencer for the RV32I core. It sits beside the instruction decoder and consumes the decoder's `ins_illegal`, `ecall`, `ebreak` and `trap_return` flags. It owns the machine trap CSRs: mstatus.MIE/MPIE, mie.MEIE, mip.MEIP, mtvec, mepc, mcause and mtval. It flushes the trapping instruction and holds a PC redirect to fetch until fetch accepts it.

## Interface
- `MTVEC_RESET`, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored)
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `valid`  in  1  decode-stage instruction is valid this cycle
- `pc`  in  32  PC of the decode-stage instruction
- `ins`  in  32  raw instruction word
- `ins_illegal`, `ecall`, `ebreak`, `trap_return`  in  1 each  decoder flags
- `irq_ext`  in  1  level-sensitive external interrupt
- `csr_wen`  in  1  CSR write strobe (already-resolved write/set/clear value)
- `csr_waddr`  in  12  CSR write address
- `csr_wdata`  in  32  CSR write data
- `csr_raddr`  in  12  CSR read address
- `csr_rdata`  out  32  combinational read data; 0 for unowned addresses
- `csr_hit`  out  1  `csr_raddr` is owned by this block
- `flush`  out  1  kill the decode-stage instruction (no rd/CSR/dmem write)
- `stall`  out  1  freeze fetch/decode
- `redirect_valid`  out  1  redirect request to fetch
- `redirect_pc`  out  32  redirect target
- `redirect_ready`  in  1  fetch accepts the redirect this cycle

## Operation
- **CSR map**
  - mstatus 0x300: MIE is bit 3, MPIE is bit 7, MPP reads 2'b11, all other bits read 0.
  - mie 0x304: only MEIE (bit 11) is writable.
  - mtvec 0x305.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only; MEIP (bit 11) = `irq_ext`.
- **States**: IDLE, REDIRECT.
- **Trap evaluation**, in IDLE with `valid`=1, highest priority first:
  1. Interrupt: `irq_ext & MIE & MEIE`. mcause=0x8000_000B, mtval=0.
  2. Illegal instruction: `ins_illegal`. mcause=2, mtval=`ins`.
  3. Breakpoint: `ebreak`. mcause=3, mtval=`pc`.
  4. Environment call: `ecall`. mcause=11, mtval=0.
- **Trap taken**
  - `flush`=1 in that same cycle.
  - At the clock edge: mepc←`pc`, mcause and mtval updated, MPIE←MIE, MIE←0.
  - Next state is REDIRECT, with the target latched.
- **mret** (`trap_return`, no trap pending)
  - `flush`=1 in that same cycle.
  - At the clock edge: MIE←MPIE, MPIE←1; the target is latched from the current mepc.
  - Next state is REDIRECT.
- **REDIRECT**
  - `redirect_valid`=1 and `stall`=1.
  - `redirect_pc` holds the latched target, stable until accepted.
  - `redirect_valid & redirect_ready` moves the state to IDLE.
- **Trap target**: mtvec base (mtvec & ~3). Vectored targets are covered under Configuration.
- **CSR writes**
  - Applied at the edge only in IDLE, and only if no trap or mret is taken that cycle; otherwise the write is dropped.
  - Writes to mtvec clear bits [1:0]; writes to mepc clear bits [1:0].
  - Writes to mip or unowned addresses are ignored.
- **Simultaneous events**: a trap and `trap_return` in the same cycle → the trap wins. `valid`=0 → no event is evaluated, including interrupts.

## Timing
- **Reset**: state=IDLE; mtvec=`MTVEC_RESET`&~3; mepc, mcause, mtval, MIE, MPIE and MEIE all 0.
  - Output values under reset: `flush`=0, `stall`=0, `redirect_valid`=0, `redirect_pc`=0.
- **Latency**: event in cycle N → `redirect_valid` from N+1, held until the handshake cycle. Minimum turnaround is 2 cycles from event back to IDLE.
- **Output timing**: `flush` is combinational from the inputs in IDLE. `stall` and `redirect_valid` are registered, derived from state.
- **Reset during REDIRECT**: the state returns to IDLE and the redirect is abandoned; the CSRs take their reset values.
- **`irq_ext` during REDIRECT**: not evaluated; it is sampled again in the first IDLE cycle with `valid`.
- **`csr_rdata` after a trap**: reflects the updated CSR values from the cycle after the trap edge.

## Configuration
- **`TRAP_VECTORED_EN` defined**
  - mtvec[1:0] is writable; MODE=1 selects vectored mode.
  - Interrupt target = base + 4×(mcause[30:0]); exceptions still go to base.
  - The interrupt target is computed from the mtvec value at the trap edge.
- **`TRAP_VECTORED_EN` undefined**: mtvec[1:0] is hardwired to 0 and every target is base (direct mode only).

## Test plan
- **Illegal instruction**: reset with mtvec written 0x100; `valid`, `ins_illegal`, pc=0x40, ins=0xFFFF_FFFF → `flush` in the same cycle. Next cycle: `redirect_valid`, pc 0x100. mepc=0x40, mcause=2, mtval=0xFFFF_FFFF.
- **ecall then mret**: MIE=1, ecall at pc 0x80 → mcause=11, MIE=0, MPIE=1. mret → `redirect_pc`=0x80, MIE=1, MPIE=1.
- **Redirect backpressure and reset**: `redirect_ready` held 0 for 3 cycles → `redirect_valid` and `redirect_pc` stable for all 3. Then `rst_n`=0 during REDIRECT → IDLE, `redirect_valid`=0, mtvec=`MTVEC_RESET`.
- **Interrupt priority and CSR drop**: MIE=1, MEIE=1, `irq_ext`=1 with `ebreak` at pc 0x20 → mcause=0x8000_000B, mepc=0x20, mtval=0. A `csr_wen` in the same cycle is dropped.
- **Masking**: `irq_ext`=1 with MIE=0 → no trap; mip reads 0x800.
- **Vectored mode** (`TRAP_VECTORED_EN`): mtvec=0x201 (base 0x200) with an interrupt → target 0x22C. An illegal instruction → target 0x200.
